reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_pkg.sv | 14 +
 rtl/reg_writeback_wb_fifo.sv | 53 +++++
 rtl/reg_writeback.sv | 113 +++++++++++
 tb/tb_reg_writeback.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared widths and the writeback beat type used by the writeback stage and its ALU buffer.
package reg_writeback_pkg;

  localparam int REG_W             = 5;
  localparam int DATA_W            = 32;
  localparam int REG_CNT           = 32;
  localparam int DEF_ALU_BUF_DEPTH = 2;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] dt;
  } wb_beat_t;

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// Parameterised synchronous FIFO holding ALU results that lost writeback arbitration.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is not reset; count/pointers alone define validity, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback arbiter: loads first, then buffered ALU results in order, plus a pending-write scoreboard.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int ALU_BUF_DEPTH = DEF_ALU_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_vld,
  input  logic [REG_W-1:0]  alu_dst,
  input  logic [DATA_W-1:0] alu_dt,
  output logic              alu_rdy,
  input  logic              mem_vld,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_dt,
  input  logic              issue_vld,
  input  logic [REG_W-1:0]  issue_dst,
  input  logic [REG_W-1:0]  chk_reg1,
  input  logic [REG_W-1:0]  chk_reg2,
  output logic              busy1,
  output logic              busy2,
  output logic [REG_W-1:0]  wr_reg,
  output logic [DATA_W-1:0] wr_dt,
  output logic              reg_wr
);

  localparam int CW = $clog2(ALU_BUF_DEPTH) + 1;

  wb_beat_t           head;
  wb_beat_t           alu_beat;
  wb_beat_t           sel;
  logic               sel_vld;
  logic               buf_push;
  logic               buf_pop;
  logic               buf_full;
  logic               buf_empty;
  logic [CW-1:0]      unused_count;
  logic               alu_acc;
  logic [REG_CNT-1:0] pending;
  logic [REG_CNT-1:0] set_mask;
  logic [REG_CNT-1:0] clr_mask;

  assign alu_beat = '{dst: alu_dst, dt: alu_dt};
  assign alu_rdy  = !buf_full;
  assign alu_acc  = alu_vld && alu_rdy;

  wb_fifo #(
    .DEPTH (ALU_BUF_DEPTH),
    .WIDTH ($bits(wb_beat_t))
  ) u_alu_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (alu_beat),
    .dout  (head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (unused_count)
  );

  // An accepted ALU beat bypasses the buffer only when nothing older or higher priority is waiting.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    sel_vld  = 1'b0;
    sel      = '0;
    buf_push = 1'b0;
    buf_pop  = 1'b0;
    if (mem_vld) begin
      sel_vld  = 1'b1;
      sel      = '{dst: mem_dst, dt: mem_dt};
      buf_push = alu_acc;
    end else if (!buf_empty) begin
      sel_vld  = 1'b1;
      sel      = head;
      buf_pop  = 1'b1;
      buf_push = alu_acc;
    end else if (alu_acc) begin
      sel_vld  = 1'b1;
      sel      = alu_beat;
    end
  end

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (sel_vld)   clr_mask[sel.dst]   = 1'b1;
    if (issue_vld) set_mask[issue_dst] = 1'b1;
    set_mask[0] = 1'b0;
  end

  assign busy1 = pending[chk_reg1];
  assign busy2 = pending[chk_reg2];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wr  <= 1'b0;
      wr_reg  <= '0;
      wr_dt   <= '0;
      pending <= '0;
    end else begin
      reg_wr  <= sel_vld && (sel.dst != '0);
      if (sel_vld) begin
        wr_reg <= sel.dst;
        wr_dt  <= sel.dt;
      end
      // Applying the set after the clear makes a same-cycle issue win.
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Randomised and directed bench for reg_writeback against a queue-based reference model.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_vld, mem_vld, issue_vld;
  logic [REG_W-1:0]  alu_dst, mem_dst, issue_dst, chk_reg1, chk_reg2;
  logic [DATA_W-1:0] alu_dt, mem_dt;
  logic              alu_rdy, busy1, busy2, reg_wr;
  logic [REG_W-1:0]  wr_reg;
  logic [DATA_W-1:0] wr_dt;

  always #5 clk = ~clk;

  reg_writeback #(.ALU_BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_vld(alu_vld), .alu_dst(alu_dst), .alu_dt(alu_dt), .alu_rdy(alu_rdy),
    .mem_vld(mem_vld), .mem_dst(mem_dst), .mem_dt(mem_dt),
    .issue_vld(issue_vld), .issue_dst(issue_dst),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .busy1(busy1), .busy2(busy2),
    .wr_reg(wr_reg), .wr_dt(wr_dt), .reg_wr(reg_wr)
  );

  // Reference model: waiting ALU results in arrival order, a per-register pending flag, expected write port.
  wb_beat_t          q[$];
  bit                pend[REG_CNT];
  logic              e_wr;
  logic [REG_W-1:0]  e_reg;
  logic [DATA_W-1:0] e_dt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    e_wr  = 1'b0;
    e_reg = '0;
    e_dt  = '0;
  endtask

  task automatic model_step();
    bit       acc, taken, have;
    wb_beat_t w;
    acc   = alu_vld && (q.size() < DEPTH);
    taken = 1'b0;
    have  = 1'b1;
    if (mem_vld)            w = '{dst: mem_dst, dt: mem_dt};
    else if (q.size() > 0)  w = q.pop_front();
    else if (acc) begin     w = '{dst: alu_dst, dt: alu_dt}; taken = 1'b1; end
    else                    have = 1'b0;
    if (acc && !taken) q.push_back('{dst: alu_dst, dt: alu_dt});
    e_wr = have && (w.dst != 0);
    if (have) begin
      e_reg = w.dst;
      e_dt  = w.dt;
      pend[w.dst] = 1'b0;
    end
    if (issue_vld && issue_dst != 0) pend[issue_dst] = 1'b1;
  endtask

  // Called at a falling edge: drive inputs, check combinational outputs, advance the model, check the write port.
  task automatic cycle(input logic av, input logic [4:0] ad, input logic [31:0] adt,
                       input logic mv, input logic [4:0] md, input logic [31:0] mdt,
                       input logic iv, input logic [4:0] id,
                       input logic [4:0] c1, input logic [4:0] c2);
    alu_vld = av; alu_dst = ad; alu_dt = adt;
    mem_vld = mv; mem_dst = md; mem_dt = mdt;
    issue_vld = iv; issue_dst = id;
    chk_reg1 = c1; chk_reg2 = c2;
    #1;
    check("alu_rdy", alu_rdy, q.size() < DEPTH);
    check("busy1", busy1, pend[c1]);
    check("busy2", busy2, pend[c2]);
    model_step();
    @(negedge clk);
    check("reg_wr", reg_wr, e_wr);
    if (e_wr) begin
      check("wr_reg", wr_reg, e_reg);
      check("wr_dt", wr_dt, e_dt);
    end
  endtask

  task automatic idle(input int n, input logic [4:0] c1);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  task automatic do_reset(input logic [4:0] c1);
    rst = 1'b1;
    alu_vld = 0; mem_vld = 0; issue_vld = 0;
    alu_dst = 0; mem_dst = 0; issue_dst = 0; alu_dt = 0; mem_dt = 0;
    chk_reg1 = c1; chk_reg2 = 0;
    #1;
    model_reset();
    check("rst_reg_wr", reg_wr, 0);
    check("rst_wr_reg", wr_reg, 0);
    check("rst_wr_dt", wr_dt, 0);
    check("rst_alu_rdy", alu_rdy, 1);
    check("rst_busy1", busy1, 0);
    check("rst_busy2", busy2, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    do_reset(0);

    // Single ALU beat into an idle stage is written one cycle later.
    cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0, 5, 0);
    idle(2, 0);

    // Load and ALU in the same cycle: load first, ALU next.
    cycle(1, 4, 32'hB, 1, 3, 32'hA, 0, 0, 0, 0);
    idle(3, 0);

    // Load held four cycles while ALU offers three beats; the third waits for space.
    cycle(1, 10, 32'h100, 1, 20, 32'h200, 0, 0, 0, 0);
    cycle(1, 11, 32'h101, 1, 21, 32'h201, 0, 0, 0, 0);
    cycle(1, 12, 32'h102, 1, 22, 32'h202, 0, 0, 0, 0);
    cycle(1, 12, 32'h102, 1, 23, 32'h203, 0, 0, 0, 0);
    cycle(1, 12, 32'h102, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 12, 32'h102, 0, 0, 0, 0, 0, 0, 0);
    idle(4, 0);

    // Scoreboard: issue r7, observe busy, clear by write, then issue and write in the same cycle.
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(2, 7);
    check("busy1_r7_set", busy1, 1);
    cycle(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 7);
    idle(2, 7);
    check("busy1_r7_clr", busy1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cycle(0, 0, 0, 1, 7, 32'h70, 1, 7, 7, 0);
    idle(2, 7);
    check("busy1_r7_setwins", busy1, 1);
    cycle(0, 0, 0, 1, 7, 32'h71, 0, 0, 7, 0);
    idle(2, 7);

    // Register 0 is never written nor marked pending.
    cycle(1, 0, 32'hFFFF, 0, 0, 0, 1, 0, 0, 0);
    idle(2, 0);
    check("busy_r0", busy1, 0);

    // Reset with two buffered beats and r9 pending discards everything.
    cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    cycle(1, 9, 32'h900, 1, 1, 32'h1, 0, 0, 9, 0);
    cycle(1, 9, 32'h901, 1, 2, 32'h2, 0, 0, 9, 0);
    check("prefill_full", alu_rdy, 0);
    do_reset(9);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
      check("no_r9_after_rst", reg_wr && (wr_reg == 9), 0);
    end

    // Randomised traffic with small register numbers to provoke hazards and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset(5'($urandom_range(0, 7)));
      else cycle(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
    idle(4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
